// File: rtl/aes_ctr_ctrl.sv
// AES-128 counter-mode streaming controller plus its single-cycle combinational core.
// aes_1cc holds byte 0 in bits [7:0]; the controller byte-swaps at its boundary so ports stay in FIPS order.

module aes_1cc (
   input  logic [127:0] g_input,
   input  logic [127:0] e_input,
   output logic [127:0] o
);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         p = p ^ (b[i] ? t : 8'h00);
         t = xtime(t);
      end
      return p;
   endfunction

   // S-box as the affine map of the field inverse a^254 (zero maps to zero naturally)
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] r;
      r = a;
      for (int i = 0; i < 6; i++) begin
         r = gf_mul(gf_mul(r, r), a);
      end
      r = gf_mul(r, r);
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rcon);
      logic [31:0]  t;
      logic [127:0] n;
      t = {sbox(k[103:96]), sbox(k[127:120]), sbox(k[119:112]), sbox(k[111:104])} ^ {24'h000000, rcon};
      n[31:0]   = k[31:0]   ^ t;
      n[63:32]  = k[63:32]  ^ n[31:0];
      n[95:64]  = k[95:64]  ^ n[63:32];
      n[127:96] = k[127:96] ^ n[95:64];
      return n;
   endfunction

   // SubBytes and ShiftRows fused into one gather; MixColumns skipped on the final round
   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
      logic [7:0]   b [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] r;
      for (int c = 0; c < 4; c++) begin
         for (int w = 0; w < 4; w++) begin
            b[4*c+w] = sbox(s[8*(4*((c+w)%4)+w) +: 8]);
         end
      end
      for (int c = 0; c < 4; c++) begin
         a0 = b[4*c];
         a1 = b[4*c+1];
         a2 = b[4*c+2];
         a3 = b[4*c+3];
         r[32*c +: 32] = last ? {a3, a2, a1, a0} :
                         {xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3),
                          a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                          a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                          xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3};
      end
      return r ^ rk;
   endfunction

   function automatic logic [127:0] aes_encrypt(input logic [127:0] k, input logic [127:0] pt);
      logic [127:0] st;
      logic [127:0] rk;
      logic [7:0]   rc;
      st = pt ^ k;
      rk = k;
      rc = 8'h01;
      for (int i = 1; i <= 10; i++) begin
         rk = key_step(rk, rc);
         rc = xtime(rc);
         st = aes_round(st, rk, (i == 10) ? 1'b1 : 1'b0);
      end
      return st;
   endfunction

   assign o = aes_encrypt(g_input, e_input);

endmodule

module aes_ctr_ctrl #(
   parameter int NB_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [127:0]    key,
   input  logic [127:0]    iv,
   input  logic [NB_W-1:0] nblocks,
   input  logic [127:0]    din,
   input  logic            din_valid,
   output logic            din_ready,
   output logic [127:0]    dout,
   output logic            dout_valid,
   input  logic            dout_ready,
   output logic            busy,
   output logic            done
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2} state_t;

   localparam logic [NB_W-1:0] REM_ZERO = {NB_W{1'b0}};
   localparam logic [NB_W-1:0] REM_ONE  = {{(NB_W-1){1'b0}}, 1'b1};

   state_t          state_r, state_nx_s;
   logic [127:0]    key_q, ctr_q;
   logic [NB_W-1:0] rem_q;
   logic [127:0]    core_key_s, core_blk_s, core_o_s, keystream_s;
   logic            accept_s, out_hs_s, latch_s, done_nx_s;

   function automatic logic [127:0] bswap(input logic [127:0] v);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) begin
         r[8*i +: 8] = v[8*(15-i) +: 8];
      end
      return r;
   endfunction

   function automatic logic [127:0] inc32(input logic [127:0] c);
      return {c[127:32], c[31:0] + 32'd1};
   endfunction

   assign core_key_s  = bswap(key_q);
   assign core_blk_s  = bswap(ctr_q);
   assign keystream_s = bswap(core_o_s);
   assign busy        = (state_r != ST_IDLE);

   aes_1cc u_core (
      .g_input (core_key_s),
      .e_input (core_blk_s),
      .o       (core_o_s)
   );

   // Next-state, input acceptance and command latch/complete decisions
   always_comb begin
      state_nx_s = state_r;
      din_ready  = 1'b0;
      latch_s    = 1'b0;
      done_nx_s  = 1'b0;
      out_hs_s   = dout_valid && dout_ready;
      case (state_r)
         ST_IDLE: begin
            if (start && (nblocks != REM_ZERO)) begin
               latch_s    = 1'b1;
               state_nx_s = ST_RUN;
            end else if (start) begin
               done_nx_s = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            din_ready = (rem_q != REM_ZERO) && (!dout_valid || dout_ready);
            if (din_valid && din_ready && (rem_q == REM_ONE)) begin
               state_nx_s = ST_FLUSH;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (out_hs_s) begin
               state_nx_s = ST_IDLE;
               done_nx_s  = 1'b1;
            end else begin
               state_nx_s = ST_FLUSH;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
      accept_s = din_valid && din_ready;
   end

   // State, command registers and the output block register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         key_q      <= 128'h0;
         ctr_q      <= 128'h0;
         rem_q      <= REM_ZERO;
         dout       <= 128'h0;
         dout_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         done    <= done_nx_s;
         if (latch_s) begin
            key_q <= key;
            ctr_q <= iv;
            rem_q <= nblocks;
         end else if (accept_s) begin
            ctr_q <= inc32(ctr_q);
            rem_q <= rem_q - REM_ONE;
         end
         // an accept coinciding with a handshake overwrites in place and keeps valid high
         if (accept_s) begin
            dout       <= din ^ keystream_s;
            dout_valid <= 1'b1;
         end else if (out_hs_s) begin
            dout_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_aes_ctr_ctrl.sv
// Directed, table-driven bench for aes_ctr_ctrl with an independent FIPS-order AES-128 reference.

module tb_aes_ctr_ctrl;

   localparam int NB_W = 16;

   logic            clk = 1'b0;
   logic            rst, start;
   logic [127:0]    key, iv, din, dout;
   logic [NB_W-1:0] nblocks;
   logic            din_valid, din_ready, dout_valid, dout_ready, busy, done;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] sb [256];

   typedef struct {
      logic [127:0]    key;
      logic [127:0]    iv;
      logic [127:0]    din_base;
      logic [127:0]    kat;
      logic [NB_W-1:0] nb;
      bit              has_kat;
      int              stall_at;
      int              stall_len;
      bit              poke;
   } vec_t;

   vec_t tbl [6];

   aes_ctr_ctrl #(.NB_W(NB_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .key        (key),
      .iv         (iv),
      .nblocks    (nblocks),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mul2(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // S-box table walked out along the generator-3 cycle and its inverse
   task automatic build_sbox();
      logic [7:0] p, q;
      p = 8'h01;
      q = 8'h01;
      for (int i = 0; i < 255; i++) begin
         p = p ^ mul2(p);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'b0000};
         if (q[7]) q = q ^ 8'h09;
         sb[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
      end
      sb[0] = 8'h63;
   endtask

   function automatic logic [127:0] model_aes(input logic [127:0] k, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   st [16];
      logic [7:0]   tmp [16];
      logic [31:0]  t;
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h000000};
            rc = mul2(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) tmp[i] = sb[st[(i + 4*(i%4)) % 16]];
         if (r != 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = tmp[4*c]; a1 = tmp[4*c+1]; a2 = tmp[4*c+2]; a3 = tmp[4*c+3];
               tmp[4*c]   = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
               tmp[4*c+1] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
               tmp[4*c+2] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
               tmp[4*c+3] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
            end
         end
         for (int i = 0; i < 16; i++) st[i] = tmp[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
      return res;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Issue one command and stream its blocks, checking every output and the done timing
   task automatic run_cmd(input vec_t v);
      int sent, got, cyc, first_hs, last_hs;
      bit done_seen;
      logic [127:0] held, ctr, dj;
      @(negedge clk);
      start = 1'b1; key = v.key; iv = v.iv; nblocks = v.nb;
      din_valid = 1'b0; dout_ready = 1'b1;
      @(negedge clk);
      key = ~v.key; iv = ~v.iv; nblocks = {NB_W{1'b1}};
      sent = 0; got = 0; cyc = 0; first_hs = -1; last_hs = -1; done_seen = 1'b0; held = 128'h0;
      while (!done_seen && cyc < 100) begin
         start      = (v.poke && cyc == 1) ? 1'b1 : 1'b0;
         nblocks    = (v.poke && cyc == 1) ? 16'd2 : {NB_W{1'b1}};
         din_valid  = (sent < int'(v.nb));
         din        = v.din_base ^ {96'h0, 32'(sent)};
         dout_ready = !(cyc >= v.stall_at && cyc < v.stall_at + v.stall_len);
         #1;
         if (cyc == 0) begin
            chk1("din_ready_latency", din_ready, 1'b1);
            chk1("busy_in_run", busy, 1'b1);
         end
         if (done) begin
            done_seen = 1'b1;
            chki("done_after_last_hs", cyc, last_hs + 1);
            chki("block_count", got, int'(v.nb));
            chk1("busy_at_done", busy, 1'b0);
         end else begin
            if (!dout_ready) begin
               chk1("stall_valid", dout_valid, 1'b1);
               chk1("stall_din_ready", din_ready, 1'b0);
               if (cyc == v.stall_at) held = dout;
               else chk("stall_hold", dout, held);
            end
            if (dout_valid && dout_ready) begin
               ctr = {v.iv[127:32], v.iv[31:0] + 32'(got)};
               dj  = v.din_base ^ {96'h0, 32'(got)};
               chk("dout_block", dout, dj ^ model_aes(v.key, ctr));
               if (v.has_kat && got == 0) chk("dout_kat", dout, v.kat);
               if (first_hs < 0) first_hs = cyc;
               last_hs = cyc;
               got++;
            end
            if (din_valid && din_ready) sent++;
         end
         @(negedge clk);
         cyc++;
      end
      if (!done_seen) begin
         n_cmp++;
         n_err++;
         $display("FAIL cmd_timeout: got no done, expected done within 100 cycles");
      end
      chki("first_output_latency", first_hs, 1);
      if (v.stall_len == 0) chki("throughput", last_hs - first_hs, int'(v.nb) - 1);
      start = 1'b0; din_valid = 1'b0;
      #1;
      chk1("done_one_cycle", done, 1'b0);
      chk1("idle_no_valid", dout_valid, 1'b0);
   endtask

   initial begin
      build_sbox();
      tbl[0] = '{key: 128'he4dc18adf3d05ec9e4dcc41acb990007, iv: 128'h4072da1240f930f7d3c8cf8b9322042e,
                 din_base: 128'h0, kat: 128'hd225406f484809186cb5d86be4098445, nb: 16'd1,
                 has_kat: 1'b1, stall_at: -1, stall_len: 0, poke: 1'b0};
      tbl[1] = '{key: 128'he4dc18adf3d05ec9e4dcc41acb990007, iv: 128'h4072da1240f930f7d3c8cf8b9322042e,
                 din_base: {128{1'b1}}, kat: 128'h2ddabf90b7b7f6e7934a27941bf67bba, nb: 16'd1,
                 has_kat: 1'b1, stall_at: -1, stall_len: 0, poke: 1'b0};
      tbl[2] = '{key: 128'h000102030405060708090a0b0c0d0e0f, iv: 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff,
                 din_base: 128'h00112233445566778899aabbccddeeff, kat: 128'h0, nb: 16'd4,
                 has_kat: 1'b0, stall_at: -1, stall_len: 0, poke: 1'b0};
      tbl[3] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, iv: 128'h0123456789abcdef00000000fffffffe,
                 din_base: 128'h5a5a5a5aa5a5a5a55a5a5a5aa5a5a5a5, kat: 128'h0, nb: 16'd3,
                 has_kat: 1'b0, stall_at: 2, stall_len: 5, poke: 1'b0};
      tbl[4] = '{key: 128'h8e73b0f7da0e6452c810f32b809079e5, iv: 128'h00112233445566778899aabbffffffff,
                 din_base: 128'hdeadbeef0badf00dcafebabe12345678, kat: 128'h0, nb: 16'd2,
                 has_kat: 1'b0, stall_at: -1, stall_len: 0, poke: 1'b0};
      tbl[5] = '{key: 128'h603deb1015ca71be2b73aef0857d7781, iv: 128'hcafebabecafebabecafebabe00000010,
                 din_base: 128'h0f0e0d0c0b0a09080706050403020100, kat: 128'h0, nb: 16'd2,
                 has_kat: 1'b0, stall_at: -1, stall_len: 0, poke: 1'b1};

      rst = 1'b1; start = 1'b0; key = 128'h0; iv = 128'h0; nblocks = '0;
      din = 128'h0; din_valid = 1'b0; dout_ready = 1'b0;
      #2;
      chk1("rst_din_ready", din_ready, 1'b0);
      chk1("rst_dout_valid", dout_valid, 1'b0);
      chk("rst_dout", dout, 128'h0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // zero-length command completes in the next cycle with no output
      @(negedge clk);
      start = 1'b1; nblocks = '0; key = tbl[0].key; iv = tbl[0].iv;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk1("zero_done", done, 1'b1);
      chk1("zero_no_valid", dout_valid, 1'b0);
      chk1("zero_not_busy", busy, 1'b0);
      @(negedge clk);
      #1;
      chk1("zero_done_once", done, 1'b0);

      for (int i = 0; i < 6; i++) run_cmd(tbl[i]);

      // reset after the first of three blocks aborts with no done
      @(negedge clk);
      start = 1'b1; key = tbl[2].key; iv = tbl[2].iv; nblocks = 16'd3;
      din = tbl[2].din_base; din_valid = 1'b1; dout_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1;
      chk1("rstmid_first_valid", dout_valid, 1'b1);
      chk("rstmid_first_block", dout, tbl[2].din_base ^ model_aes(tbl[2].key, tbl[2].iv));
      #1;
      rst = 1'b1;
      #1;
      chk1("rstmid_dout_valid", dout_valid, 1'b0);
      chk("rstmid_dout", dout, 128'h0);
      chk1("rstmid_busy", busy, 1'b0);
      chk1("rstmid_din_ready", din_ready, 1'b0);
      chk1("rstmid_done", done, 1'b0);
      @(negedge clk);
      rst = 1'b0; din_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk1("rstmid_no_done", done, 1'b0);
      end
      run_cmd(tbl[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
